// File: rtl/l2_cache_control.sv
// Control FSM for a 4-way set-associative write-back L2 with tree pseudo-LRU.
// Optional performance counters are built only when L2_PERF_CNT_EN is defined.
module l2_cache_control #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 l2_read,
  input  logic                 l2_write,
  output logic                 l2_resp,
  input  logic [7:0]           way_state,
  input  logic [2:0]           lru_in,
  output logic [20:0]          ctl,
  output logic [2:0]           lru_out,
  output logic [1:0]           way_sel,
  output logic                 datain_sel,
  output logic                 pmem_addr_sel,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 pmem_resp,
  output logic [CNT_WIDTH-1:0] hit_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt,
  output logic [CNT_WIDTH-1:0] wb_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TAG   = 2'd1,
    WB    = 2'd2,
    ALLOC = 2'd3
  } state_e;

  // Per-way strobe fields {load_d, load_v, load_TD, d_in, v_in}
  localparam logic [4:0] WR_HIT_FIELD = 5'b10110;
  localparam logic [4:0] FILL_FIELD   = 5'b11101;

  state_e      state_q;
  logic [1:0]  victim_q;
  logic [3:0]  hit_vec_s;
  logic [3:0]  dirty_vec_s;
  logic        any_hit_s;
  logic [1:0]  hit_way_s;
  logic [1:0]  victim_s;
  logic        req_s;
  logic        tag_hit_s;

  function automatic logic [1:0] lru_victim(input logic [2:0] lru);
    logic [1:0] v;
    if (!lru[2]) begin
      v = lru[1] ? 2'd1 : 2'd0;
    end else begin
      v = lru[0] ? 2'd3 : 2'd2;
    end
    return v;
  endfunction

  function automatic logic [2:0] lru_update(input logic [2:0] lru, input logic [1:0] w);
    logic [2:0] n;
    if (!w[1]) begin
      n = {1'b1, (w == 2'd0), lru[0]};
    end else begin
      n = {1'b0, lru[1], (w == 2'd2)};
    end
    return n;
  endfunction

  // Decode per-way status and pick the lowest-index hitting way
  always_comb begin
    hit_way_s = 2'd0;
    for (int w = 0; w < 4; w++) begin
      hit_vec_s[w]   = way_state[6-2*w];
      dirty_vec_s[w] = way_state[7-2*w];
    end
    for (int w = 3; w >= 0; w--) begin
      if (hit_vec_s[w]) begin
        hit_way_s = 2'(w);
      end else begin
        hit_way_s = hit_way_s;
      end
    end
    any_hit_s = |hit_vec_s;
    victim_s  = lru_victim(lru_in);
    req_s     = l2_read | l2_write;
    tag_hit_s = (state_q == TAG) && req_s && any_hit_s;
  end

  // Main controller state and latched victim way
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      victim_q <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_s) state_q <= TAG;
          else       state_q <= IDLE;
        end
        TAG: begin
          if (!req_s || any_hit_s) begin
            state_q <= IDLE;
          end else begin
            victim_q <= victim_s;
            state_q  <= dirty_vec_s[victim_s] ? WB : ALLOC;
          end
        end
        WB: begin
          if (pmem_resp) state_q <= ALLOC;
          else           state_q <= WB;
        end
        ALLOC: begin
          if (pmem_resp) state_q <= TAG;
          else           state_q <= ALLOC;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output decode from the registered state; IDLE drives everything low
  always_comb begin
    l2_resp       = 1'b0;
    ctl           = 21'd0;
    lru_out       = 3'd0;
    way_sel       = 2'd0;
    datain_sel    = 1'b0;
    pmem_addr_sel = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    case (state_q)
      TAG: begin
        if (tag_hit_s) begin
          l2_resp = 1'b1;
          ctl[20] = 1'b1;
          lru_out = lru_update(lru_in, hit_way_s);
          way_sel = hit_way_s;
          if (l2_write) begin
            datain_sel = 1'b1;
            for (int w = 0; w < 4; w++) begin
              if (2'(w) == hit_way_s) ctl[19-5*w -: 5] = WR_HIT_FIELD;
              else                    ctl[19-5*w -: 5] = 5'd0;
            end
          end else begin
            datain_sel = 1'b0;
          end
        end else begin
          l2_resp = 1'b0;
        end
      end
      WB: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        way_sel       = victim_q;
      end
      ALLOC: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          for (int w = 0; w < 4; w++) begin
            if (2'(w) == victim_q) ctl[19-5*w -: 5] = FILL_FIELD;
            else                   ctl[19-5*w -: 5] = 5'd0;
          end
        end else begin
          ctl = 21'd0;
        end
      end
      default: begin
        l2_resp = 1'b0;
      end
    endcase
  end

`ifdef L2_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] hit_cnt_q;
  logic [CNT_WIDTH-1:0] miss_cnt_q;
  logic [CNT_WIDTH-1:0] wb_cnt_q;
  logic                 from_idle_q;
  logic                 tag_miss_s;
  logic                 wb_done_s;

  always_comb begin
    tag_miss_s = (state_q == TAG) && req_s && !any_hit_s;
    wb_done_s  = (state_q == WB) && pmem_resp;
  end

  // Saturating counters; refill re-lookups (TAG entered from ALLOC) are not hits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q   <= {CNT_WIDTH{1'b0}};
      miss_cnt_q  <= {CNT_WIDTH{1'b0}};
      wb_cnt_q    <= {CNT_WIDTH{1'b0}};
      from_idle_q <= 1'b0;
    end else begin
      if (state_q == IDLE && req_s)          from_idle_q <= 1'b1;
      else if (state_q == ALLOC && pmem_resp) from_idle_q <= 1'b0;
      else                                   from_idle_q <= from_idle_q;
      if (tag_hit_s && from_idle_q && hit_cnt_q != {CNT_WIDTH{1'b1}})
        hit_cnt_q <= hit_cnt_q + CNT_WIDTH'(1);
      else
        hit_cnt_q <= hit_cnt_q;
      if (tag_miss_s && miss_cnt_q != {CNT_WIDTH{1'b1}})
        miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
      else
        miss_cnt_q <= miss_cnt_q;
      if (wb_done_s && wb_cnt_q != {CNT_WIDTH{1'b1}})
        wb_cnt_q <= wb_cnt_q + CNT_WIDTH'(1);
      else
        wb_cnt_q <= wb_cnt_q;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`else
  assign hit_cnt  = {CNT_WIDTH{1'b0}};
  assign miss_cnt = {CNT_WIDTH{1'b0}};
  assign wb_cnt   = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_l2_cache_control.sv
// Directed bench for l2_cache_control: hit vector table plus miss/writeback/reset sequences.
// Counter checks follow L2_PERF_CNT_EN (saturation checked with CNT_WIDTH=2).
module tb_l2_cache_control;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          l2_read = 1'b0;
  logic          l2_write = 1'b0;
  logic          pmem_resp = 1'b0;
  logic [7:0]    way_state = 8'd0;
  logic [2:0]    lru_in = 3'd0;
  logic          l2_resp;
  logic [20:0]   ctl;
  logic [2:0]    lru_out;
  logic [1:0]    way_sel;
  logic          datain_sel;
  logic          pmem_addr_sel;
  logic          pmem_read;
  logic          pmem_write;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;
  logic [CW-1:0] wb_cnt;

  int checks = 0;
  int errors = 0;

  l2_cache_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .l2_read(l2_read), .l2_write(l2_write), .l2_resp(l2_resp),
    .way_state(way_state), .lru_in(lru_in), .ctl(ctl), .lru_out(lru_out), .way_sel(way_sel),
    .datain_sel(datain_sel), .pmem_addr_sel(pmem_addr_sel), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_resp(pmem_resp), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .wb_cnt(wb_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  ws;
    logic [2:0]  lru;
    logic [20:0] ctl;
    logic [2:0]  lru_o;
    logic [1:0]  wsel;
    logic        dsel;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [30:0] pack(input logic r, input logic [20:0] c, input logic [2:0] l,
                                       input logic [1:0] w, input logic d, input logic a,
                                       input logic pr, input logic pw);
    return {r, c, l, w, d, a, pr, pw};
  endfunction

  function automatic logic [30:0] obs();
    return {l2_resp, ctl, lru_out, way_sel, datain_sel, pmem_addr_sel, pmem_read, pmem_write};
  endfunction

  task automatic do_reset();
    l2_read = 1'b0; l2_write = 1'b0; pmem_resp = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_outputs", 64'(obs()), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_hit(input vec_t v, input string nm);
    l2_read = v.rd; l2_write = v.wr; way_state = v.ws; lru_in = v.lru;
    tick();
    chk(nm, 64'(obs()), 64'(pack(1'b1, v.ctl, v.lru_o, v.wsel, v.dsel, 1'b0, 1'b0, 1'b0)));
    tick();
    l2_read = 1'b0; l2_write = 1'b0;
    #1;
    chk({nm, "_idle"}, 64'(obs()), 64'd0);
  endtask

  task automatic dirty_miss();
    l2_write = 1'b1; lru_in = 3'b110; way_state = 8'h08;
    tick();
    chk("dm_tag", 64'(obs()), 64'd0);
    tick();
    lru_in = 3'b000;
    #1;
    chk("dm_wb", 64'(obs()), 64'(pack(1'b0, 21'd0, 3'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1)));
    tick();
    chk("dm_wb_hold", 64'(obs()), 64'(pack(1'b0, 21'd0, 3'd0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1)));
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    #1;
    chk("dm_alloc", 64'(obs()), 64'(pack(1'b0, 21'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0)));
    pmem_resp = 1'b1;
    #1;
    chk("dm_fill_way2", 64'(obs()), 64'(pack(1'b0, 21'h0003A0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0)));
    tick();
    pmem_resp = 1'b0; way_state = 8'h04;
    #1;
    chk("dm_write_hit", 64'(obs()), 64'(pack(1'b1, 21'h1002C0, 3'b001, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0)));
    tick();
    l2_write = 1'b0;
    #1;
    chk("dm_idle", 64'(obs()), 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'h04, 3'b000, 21'h100000, 3'b001, 2'd2, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h11, 3'b000, 21'h100000, 3'b100, 2'd1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h11, 3'b111, 21'h105800, 3'b101, 2'd1, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 8'h03, 3'b010, 21'h100016, 3'b010, 2'd3, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 8'hC0, 3'b011, 21'h100000, 3'b111, 2'd0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h40, 3'b000, 21'h1B0000, 3'b110, 2'd0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 8'h04, 3'b100, 21'h1002C0, 3'b001, 2'd2, 1'b1};

    do_reset();
    for (int i = 0; i < 7; i++) do_hit(vecs[i], $sformatf("hit_vec%0d", i));

    // Clean read miss: victim way0 from lru 000, fill, then re-lookup hit
    l2_read = 1'b1; way_state = 8'h00; lru_in = 3'b000;
    tick();
    chk("cm_tag", 64'(obs()), 64'd0);
    tick();
    chk("cm_alloc", 64'(obs()), 64'(pack(1'b0, 21'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0)));
    tick();
    tick();
    chk("cm_alloc_hold", 64'(obs()), 64'(pack(1'b0, 21'd0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0)));
    pmem_resp = 1'b1;
    #1;
    chk("cm_fill_way0", 64'(obs()), 64'(pack(1'b0, 21'h0E8000, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0)));
    tick();
    pmem_resp = 1'b0; way_state = 8'h40;
    #1;
    chk("cm_hit", 64'(obs()), 64'(pack(1'b1, 21'h100000, 3'b110, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)));
    tick();
    l2_read = 1'b0;
    #1;
    chk("cm_idle", 64'(obs()), 64'd0);

    dirty_miss();

    // Request dropped while in TAG must return to IDLE, not start a fill
    l2_read = 1'b1; way_state = 8'h00; lru_in = 3'b000;
    tick();
    l2_read = 1'b0;
    #1;
    chk("drop_tag", 64'(obs()), 64'd0);
    tick();
    chk("drop_idle", 64'(obs()), 64'd0);

    // Reset in the middle of ALLOC
    l2_read = 1'b1;
    tick();
    tick();
    chk("rst_alloc_pre", 64'(pmem_read), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_alloc_drop", 64'(obs()), 64'd0);
    l2_read = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_alloc_resp", 64'(l2_resp), 64'd0);
    do_hit(vecs[0], "post_reset_hit");

    // Counters: dirty miss first (refill hit not counted), then saturating hits
    do_reset();
    dirty_miss();
`ifdef L2_PERF_CNT_EN
    chk("cnt_miss", 64'(miss_cnt), 64'd1);
    chk("cnt_wb", 64'(wb_cnt), 64'd1);
    chk("cnt_hit_refill", 64'(hit_cnt), 64'd0);
    for (int i = 0; i < 5; i++) do_hit(vecs[0], "cnt_hit");
    chk("cnt_hit_sat", 64'(hit_cnt), 64'd3);
`else
    for (int i = 0; i < 5; i++) do_hit(vecs[0], "cnt_hit");
    chk("cnt_tied", 64'({hit_cnt, miss_cnt, wb_cnt}), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
